// File: rtl/quadrature_step_generator.sv
// quadrature_step_generator
//
// Emulates an EC11-style rotary encoder. Single-cycle clockwise and
// counter-clockwise requests are accumulated in a saturating signed pending
// counter. Each queued step is played out as one full two-phase quadrature
// cycle on out_a/out_b. Every phase is held for HOLD_CYCLES clocks, and the
// outputs rest at 11 for HOLD_CYCLES clocks after the last transition of each
// step, so a debouncing decoder downstream can resolve every detent.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset (abandons any running step)
//   in_cw    - one-cycle strobe, request one clockwise step
//   in_ccw   - one-cycle strobe, request one counter-clockwise step
//   out_a    - quadrature phase A, registered, idle high
//   out_b    - quadrature phase B, registered, idle high
//   busy     - high while a step is being emitted (including its rest time)
//   overflow - one-cycle pulse, a request was dropped because pending saturated

module quadrature_step_generator #(
  parameter int HOLD_CYCLES   = 200,
  parameter int PENDING_WIDTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_cw,
  input  logic in_ccw,
  output logic out_a,
  output logic out_b,
  output logic busy,
  output logic overflow
);

  localparam int HOLD_WIDTH = $clog2(HOLD_CYCLES + 1);
  localparam int EXT_WIDTH  = PENDING_WIDTH + 2;

  localparam logic [HOLD_WIDTH-1:0]       HOLD_LAST = HOLD_WIDTH'(HOLD_CYCLES - 1);
  localparam logic signed [EXT_WIDTH-1:0] ONE_EXT   = EXT_WIDTH'(1);
  localparam logic signed [EXT_WIDTH-1:0] MAX_EXT   = EXT_WIDTH'((1 << (PENDING_WIDTH - 1)) - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                          state, state_n;
  logic [1:0]                      phase, phase_n;
  logic [HOLD_WIDTH-1:0]           hold, hold_n;
  logic                            dir_cw, dir_cw_n;
  logic signed [PENDING_WIDTH-1:0] pending, pending_n;
  logic                            out_a_n, out_b_n, busy_n, overflow_n;

  logic                            hold_done, step_end, start, start_cw;
  logic signed [EXT_WIDTH-1:0]     base, req, sum;

  // Output pattern after p transitions of a step (p=0 is the 11 rest).
  // CW walks 11->01->00->10, CCW is the same walk with A and B swapped.
  function automatic logic [1:0] phase_ab(input logic cw, input logic [1:0] p);
    logic a_bit, b_bit;
    a_bit = (p == 2'd0) || (p == 2'd3);
    b_bit = (p == 2'd0) || (p == 2'd1);
    return cw ? {a_bit, b_bit} : {b_bit, a_bit};
  endfunction

  // State register. Reset is asynchronous so a running step is dropped
  // immediately and the outputs snap back to the 11 rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      phase    <= 2'd0;
      hold     <= '0;
      dir_cw   <= 1'b0;
      pending  <= '0;
      out_a    <= 1'b1;
      out_b    <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      hold     <= hold_n;
      dir_cw   <= dir_cw_n;
      pending  <= pending_n;
      out_a    <= out_a_n;
      out_b    <= out_b_n;
      busy     <= busy_n;
      overflow <= overflow_n;
    end
  end

  // Next-state logic. In RUN, phase 1..3 means that many transitions have
  // been applied; phase wraps to 0 on the fourth transition and then marks
  // the closing rest period. A new step starts either from IDLE or right at
  // the end of that rest, in the same edge, so busy never drops in between.
  // Step-start consumption and request intake are summed in a wider signed
  // value so saturation is judged on the combined result.
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    hold_n     = hold;
    dir_cw_n   = dir_cw;
    pending_n  = pending;
    out_a_n    = out_a;
    out_b_n    = out_b;
    busy_n     = busy;
    overflow_n = 1'b0;

    hold_done = (hold == HOLD_LAST);
    step_end  = (state == RUN) && hold_done && (phase == 2'd0);
    start     = ((state == IDLE) || step_end) && (pending != '0);
    start_cw  = !pending[PENDING_WIDTH-1];

    base = EXT_WIDTH'(pending);
    if (start) begin
      base = start_cw ? (base - ONE_EXT) : (base + ONE_EXT);
    end

    req = '0;
    if (in_cw && !in_ccw) begin
      req = ONE_EXT;
    end else if (in_ccw && !in_cw) begin
      req = -ONE_EXT;
    end

    sum = base + req;
    if ((req != '0) && ((sum > MAX_EXT) || (sum < -MAX_EXT))) begin
      pending_n  = base[PENDING_WIDTH-1:0];
      overflow_n = 1'b1;
    end else begin
      pending_n  = sum[PENDING_WIDTH-1:0];
    end

    if (start) begin
      state_n            = RUN;
      phase_n            = 2'd1;
      hold_n             = '0;
      dir_cw_n           = start_cw;
      busy_n             = 1'b1;
      {out_a_n, out_b_n} = phase_ab(start_cw, 2'd1);
    end else if (state == RUN) begin
      if (hold_done) begin
        hold_n = '0;
        if (phase == 2'd0) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          phase_n            = phase + 2'd1;
          {out_a_n, out_b_n} = phase_ab(dir_cw, phase + 2'd1);
        end
      end else begin
        hold_n = hold + 1'b1;
      end
    end
  end

endmodule
